// File: rtl/valu_pkg.sv
// Shared constants and types for the vector ALU.
// VECTOR_ALU_MAC_EN enables the MAC opcode; without it opcode 2'b11 is illegal.
package valu_pkg;

    localparam int unsigned LANE_W    = 32;
    localparam int unsigned NUM_LANES = 16;
    localparam logic [2:0]  WB_ADDR   = 3'b100;

`ifdef VECTOR_ALU_MAC_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    function automatic logic op_legal(opcode_e op);
        return (op != OP_MAC) || MAC_EN;
    endfunction

endpackage

// File: rtl/vector_alu_if.sv
// Request / result bus between the register file and the vector ALU.
interface vector_alu_if;
    import valu_pkg::*;

    logic                            start;
    logic [1:0]                      opcode;
    logic [NUM_LANES*LANE_W-1:0]     a_in;
    logic [NUM_LANES*LANE_W-1:0]     b_in;
    logic                            busy;
    logic                            done;
    logic                            err;
    logic [NUM_LANES*2*LANE_W-1:0]   result;
    logic                            wb_write;
    logic [2:0]                      wb_address;

    modport master (
        output start, opcode, a_in, b_in,
        input  busy, done, err, result, wb_write, wb_address
    );

    modport slave (
        input  start, opcode, a_in, b_in,
        output busy, done, err, result, wb_write, wb_address
    );
endinterface

// File: rtl/valu_lane.sv
// One signed lane: 32-bit operands widened to a 64-bit exact (or accumulated) result.
// The accumulate port and adder exist only under VECTOR_ALU_MAC_EN.
module valu_lane
    import valu_pkg::*;
#(
    parameter int unsigned LANE_W = valu_pkg::LANE_W
) (
    input  opcode_e                 op_i,
    input  logic [LANE_W-1:0]       a_i,
    input  logic [LANE_W-1:0]       b_i,
`ifdef VECTOR_ALU_MAC_EN
    input  logic [2*LANE_W-1:0]     acc_i,
`endif
    output logic [2*LANE_W-1:0]     res_o
);

    localparam int unsigned RES_W = 2 * LANE_W;

    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] b_x;
    logic [RES_W-1:0] prod;

    // Low 2W bits of the sign-extended product equal the exact signed product.
    always_comb begin
        a_x  = {{(RES_W-LANE_W){a_i[LANE_W-1]}}, a_i};
        b_x  = {{(RES_W-LANE_W){b_i[LANE_W-1]}}, b_i};
        prod = a_x * b_x;
        case (op_i)
            OP_ADD:  res_o = a_x + b_x;
            OP_SUB:  res_o = a_x - b_x;
            OP_MUL:  res_o = prod;
`ifdef VECTOR_ALU_MAC_EN
            OP_MAC:  res_o = acc_i + prod;
`endif
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu.sv
// Chunked 16-lane vector ALU: LANES_PER_CYCLE lanes per EXEC cycle, then a write-back pulse.
// MAC support is compiled in only when VECTOR_ALU_MAC_EN is defined.
module vector_alu #(
    parameter int unsigned LANE_W          = valu_pkg::LANE_W,
    parameter int unsigned NUM_LANES       = valu_pkg::NUM_LANES,
    parameter int unsigned LANES_PER_CYCLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vector_alu_if.slave   bus
);
    import valu_pkg::*;

    localparam int unsigned RES_W      = 2 * LANE_W;
    localparam int unsigned NUM_CHUNKS = NUM_LANES / LANES_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_LANES*LANE_W-1:0]   a_q, a_d, b_q, b_d;
    opcode_e                       op_q, op_d;
    logic [NUM_LANES*RES_W-1:0]    result_q, result_d;
    logic                          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                          wb_write_q, wb_write_d;
    logic [2:0]                    wb_addr_q, wb_addr_d;

    logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] a_sel, b_sel;
    logic [LANES_PER_CYCLE-1:0][RES_W-1:0]  lane_res;
`ifdef VECTOR_ALU_MAC_EN
    logic [LANES_PER_CYCLE-1:0][RES_W-1:0]  acc_sel;
`endif

    // Route the current chunk's latched lanes to the lane datapaths.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
            idx      = 32'(cnt_q) * LANES_PER_CYCLE + j;
            a_sel[j] = a_q[idx*LANE_W +: LANE_W];
            b_sel[j] = b_q[idx*LANE_W +: LANE_W];
`ifdef VECTOR_ALU_MAC_EN
            acc_sel[j] = result_q[idx*RES_W +: RES_W];
`endif
        end
    end

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        valu_lane #(.LANE_W(LANE_W)) u_lane (
            .op_i  (op_q),
            .a_i   (a_sel[g]),
            .b_i   (b_sel[g]),
`ifdef VECTOR_ALU_MAC_EN
            .acc_i (acc_sel[g]),
`endif
            .res_o (lane_res[g])
        );
    end

    always_comb begin
        int unsigned idx;
        idx        = 0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    op_d    = opcode_e'(bus.opcode);
                    cnt_d   = '0;
                    state_d = op_legal(opcode_e'(bus.opcode)) ? ST_EXEC : ST_ERR;
                end
            end
            ST_EXEC: begin
                for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
                    idx = 32'(cnt_q) * LANES_PER_CYCLE + j;
                    result_d[idx*RES_W +: RES_W] = lane_res[j];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) state_d = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_WB) || (state_d == ST_ERR);
        err_d      = (state_d == ST_ERR);
        wb_write_d = (state_d == ST_WB);
        wb_addr_d  = (state_d == ST_WB) ? WB_ADDR : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_write_q <= 1'b0;
            wb_addr_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.result     = result_q;
    assign bus.wb_write   = wb_write_q;
    assign bus.wb_address = wb_addr_q;

endmodule

// File: tb/tb_vector_alu.sv
// Scoreboard bench for vector_alu: randomized and directed operations against a lane-level model.
module tb_vector_alu;
    import valu_pkg::*;

    localparam int unsigned NL  = NUM_LANES;
    localparam int unsigned LW  = LANE_W;
    localparam int unsigned RW  = 2 * LANE_W;
    localparam int unsigned LAT = NUM_LANES / 4;
    localparam int unsigned VW  = NL * RW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_alu_if bus();

    vector_alu #(.LANE_W(LW), .NUM_LANES(NL), .LANES_PER_CYCLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          err;
        logic [VW-1:0] res;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [RW-1:0] model[NL];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_model();
        logic [VW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*RW +: RW] = model[i];
        return v;
    endfunction

    function automatic logic [NL*LW-1:0] rep(input logic [LW-1:0] x);
        logic [NL*LW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*LW +: LW] = x;
        return v;
    endfunction

    function automatic logic [NL*LW-1:0] rand_vec();
        logic [NL*LW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*LW +: LW] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 9)) : $urandom();
        return v;
    endfunction

    // Reference: signed integer arithmetic per lane; illegal opcodes leave results alone.
    function automatic logic model_op(input logic [1:0] op, input logic [NL*LW-1:0] a, input logic [NL*LW-1:0] b);
        logic signed [LW-1:0] ta, tb;
        longint sa, sbv;
        if (op == 2'b11 && !MAC_EN) return 1'b1;
        for (int i = 0; i < NL; i++) begin
            ta  = a[i*LW +: LW];
            tb  = b[i*LW +: LW];
            sa  = ta;
            sbv = tb;
            case (op)
                2'b00:   model[i] = sa + sbv;
                2'b01:   model[i] = sa - sbv;
                2'b10:   model[i] = sa * sbv;
                default: model[i] = model[i] + sa * sbv;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (bus.busy) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 100) begin
                n_bad++;
                $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", bus.busy, guard);
                $fatal(1);
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [NL*LW-1:0] a, input logic [NL*LW-1:0] b, input bit track);
        exp_t e;
        wait_idle();
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a_in   = a;
        bus.b_in   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", VW'(bus.busy), VW'(1));
        if (track) begin
            e.err = model_op(op, a, b);
            e.res = pack_model();
            e.cyc = cyc + (e.err ? 0 : int'(LAT));
            sb.push_back(e);
        end
    endtask

    task automatic check_lane0(input string name, input logic [RW-1:0] v);
        wait_idle();
        check(name, VW'(bus.result[RW-1:0]), VW'(v));
    endtask

    // Monitor: every completion is popped against the scoreboard; strobes must be quiet otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required no completion", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", VW'(cyc), VW'(e.cyc));
                    check("err", VW'(bus.err), VW'(e.err));
                    check("wb_write", VW'(bus.wb_write), VW'(!e.err));
                    if (!e.err) check("wb_address", VW'(bus.wb_address), VW'(3'b100));
                    check("result", bus.result, e.res);
                end
            end else begin
                check("quiet_strobes", VW'({bus.wb_write, bus.err}), VW'(2'b00));
            end
        end
    end

    initial begin
        logic [NL*LW-1:0] a, b;
        bus.start  = 1'b0;
        bus.opcode = 2'b00;
        bus.a_in   = '0;
        bus.b_in   = '0;
        for (int i = 0; i < NL; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", VW'({bus.busy, bus.done, bus.err, bus.wb_write, bus.wb_address}), VW'(0));
        check("reset_result", bus.result, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, rep(32'h7FFF_FFFF), rep(32'h1), 1'b1);
        check_lane0("add_overflow_lane", 64'h0000_0000_8000_0000);
        issue(2'b01, rep(32'h0), rep(32'h1), 1'b1);
        check_lane0("sub_neg_lane", 64'hFFFF_FFFF_FFFF_FFFF);
        issue(2'b10, rep(32'h8000_0000), rep(32'h8000_0000), 1'b1);
        check_lane0("mul_minmin_lane", 64'h4000_0000_0000_0000);
        issue(2'b10, rep(32'hFFFF_FFFD), rep(32'h5), 1'b1);
        check_lane0("mul_neg_lane", 64'hFFFF_FFFF_FFFF_FFF1);
        issue(2'b10, rep(32'h2), rep(32'h3), 1'b1);
        issue(2'b11, rep(32'h4), rep(32'h5), 1'b1);
`ifdef VECTOR_ALU_MAC_EN
        check_lane0("mac_lane", 64'd26);
`else
        check_lane0("illegal_keeps_lane", 64'd6);
`endif

        // Start and operand changes while busy must be ignored.
        a = rand_vec();
        b = rand_vec();
        issue(2'b00, a, b, 1'b1);
        bus.start  = 1'b1;
        bus.opcode = 2'b10;
        bus.a_in   = ~a;
        bus.b_in   = rand_vec();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the second EXEC cycle aborts without write-back.
        issue(2'b10, rand_vec(), rand_vec(), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("reset_abort_busy", VW'(bus.busy), VW'(0));
        check("reset_abort_result", bus.result, '0);
        check("reset_abort_wb", VW'({bus.done, bus.wb_write}), VW'(0));
        for (int i = 0; i < NL; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(2'b01, rand_vec(), rand_vec(), 1'b1);

        for (int n = 0; n < 40; n++) issue(2'($urandom_range(0, 3)), rand_vec(), rand_vec(), 1'b1);

        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", VW'(sb.size()), VW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
